// File: rtl/alu_seq_unit.sv
// EX-stage ALU: decodes ALUOp/FuncField into a 4-bit Operation code and executes it.
// Logic, shift and compare ops take one cycle; mul/div run an iterative engine that stalls issue.
module alu_seq_unit #(
  parameter int unsigned WIDTH         = 32,
  parameter bit          ENABLE_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncField,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             illegal,
  output logic [3:0]       Operation,
  output logic             busy
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state;
  logic [SW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opb;   // multiplicand or divisor

  logic [3:0]         dec_op;
  logic               dec_ill;
  logic [WIDTH-1:0]   alu_res;
  logic               is_md;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  // Operation decode
  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_AND;
      2'b11: dec_op = OP_OR;
      default: begin
        case (FuncField)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b011000: dec_op = OP_MUL;
          6'b011010: dec_op = OP_DIV;
          6'b000000: dec_op = OP_SLL;
          6'b000010: dec_op = OP_SRL;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100110: dec_op = OP_XOR;
          6'b100111: dec_op = OP_NOR;
          6'b101010: dec_op = OP_SLT;
          default: begin
            dec_op  = OP_ADD;
            dec_ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign is_md = (dec_op == OP_MUL) || (dec_op == OP_DIV);

  // Single-cycle datapath; mul/div codes fall to 0 when the engine is disabled
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_SLL: alu_res = a << b[SW-1:0];
      OP_SRL: alu_res = a >> b[SW-1:0];
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : WIDTH'(0))};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      Operation <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in && !flush) begin
            Operation <= dec_op;
            ready     <= 1'b0;
            busy      <= 1'b1;
            if (is_md && ENABLE_MULDIV) begin
              illegal <= 1'b0;
              if (dec_op == OP_MUL) begin
                acc   <= {WIDTH'(0), b};
                opb   <= a;
                cnt   <= SW'(WIDTH - 1);
                state <= S_MUL;
              end else if (b == '0) begin
                result    <= '1;
                hi        <= a;
                zero      <= 1'b0;
                out_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                acc   <= {WIDTH'(0), a};
                opb   <= b;
                cnt   <= SW'(WIDTH - 1);
                state <= S_DIV;
              end
            end else begin
              result    <= alu_res;
              hi        <= '0;
              zero      <= (alu_res == '0);
              illegal   <= dec_ill | is_md;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            cnt   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            acc <= (state == S_MUL) ? mul_next : div_next;
            cnt <= cnt - SW'(1);
            if (cnt == '0) begin
              result    <= (state == S_MUL) ? mul_next[WIDTH-1:0] : div_next[WIDTH-1:0];
              hi        <= (state == S_MUL) ? mul_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
              zero      <= (state == S_MUL) ? (mul_next[WIDTH-1:0] == '0) : (div_next[WIDTH-1:0] == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        default: begin
          cnt   <= '0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed plan items plus randomized ops checked against
// an arithmetic reference model (64-bit products, native / and %).
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic        ready;
  logic [1:0]  ALUOp;
  logic [5:0]  FuncField;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        illegal;
  logic [3:0]  Operation;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_res = '0;

  alu_seq_unit #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready(ready),
    .ALUOp(ALUOp), .FuncField(FuncField), .a(a), .b(b), .out_valid(out_valid),
    .result(result), .hi(hi), .zero(zero), .illegal(illegal),
    .Operation(Operation), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected behaviour straight from the op table and plain arithmetic
  task automatic ref_model(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] x, input logic [31:0] y,
                           output logic [3:0] eop, output logic [31:0] eres,
                           output logic [31:0] ehi, output logic eill, output int elat);
    longint unsigned p;
    eop = 4'b0000; eill = 1'b0; ehi = '0; elat = 1;
    if (op == 2'b01) eop = 4'b1000;
    else if (op == 2'b11) eop = 4'b1001;
    else if (op == 2'b10) begin
      case (fn)
        6'b100000: eop = 4'b0000;
        6'b100010: eop = 4'b0001;
        6'b011000: eop = 4'b0010;
        6'b011010: eop = 4'b0011;
        6'b000000: eop = 4'b0100;
        6'b000010: eop = 4'b0101;
        6'b100100: eop = 4'b1000;
        6'b100101: eop = 4'b1001;
        6'b100110: eop = 4'b1010;
        6'b100111: eop = 4'b1011;
        6'b101010: eop = 4'b1110;
        default:   eill = 1'b1;
      endcase
    end
    case (eop)
      4'b0001: eres = x - y;
      4'b0010: begin
        p = longint'(x) * longint'(y);
        eres = p[31:0]; ehi = p[63:32]; elat = 33;
      end
      4'b0011: begin
        if (y == 0) begin eres = 32'hFFFF_FFFF; ehi = x; end
        else begin eres = x / y; ehi = x % y; elat = 33; end
      end
      4'b0100: eres = x << y[4:0];
      4'b0101: eres = x >> y[4:0];
      4'b1000: eres = x & y;
      4'b1001: eres = x | y;
      4'b1010: eres = x ^ y;
      4'b1011: eres = ~(x | y);
      4'b1110: eres = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: eres = x + y;
    endcase
  endtask

  // Issue one op (called at a negedge), scramble operands after acceptance, check the pulse
  task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] x, input logic [31:0] y, output int waited);
    logic [3:0]  eop;
    logic [31:0] eres, ehi;
    logic        eill;
    int          elat, lat;
    ref_model(op, fn, x, y, eop, eres, ehi, eill, elat);
    waited = 0;
    while (!ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_issue", 64'(ready), 64'd1);
    ALUOp = op; FuncField = fn; a = x; b = y; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    a = $urandom; b = $urandom; ALUOp = 2'($urandom); FuncField = 6'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check($sformatf("latency op=%b fn=%b", op, fn), 64'(lat), 64'(elat));
    check($sformatf("result op=%b fn=%b a=%h b=%h", op, fn, x, y), 64'(result), 64'(eres));
    check($sformatf("hi op=%b fn=%b a=%h b=%h", op, fn, x, y), 64'(hi), 64'(ehi));
    check("zero", 64'(zero), 64'(eres == 0));
    check("illegal", 64'(illegal), 64'(eill));
    check("operation", 64'(Operation), 64'(eop));
    check("ready_low_on_pulse", 64'({ready, busy}), 64'b01);
    last_res = eres;
  endtask

  initial begin
    int w;
    int pulses;
    logic [7:0] tbl [14];
    logic [7:0] sel;
    logic [31:0] x, y;

    tbl = '{8'b00_000000, 8'b01_000000, 8'b11_000000, 8'b10_100000, 8'b10_100010,
            8'b10_011000, 8'b10_011010, 8'b10_000000, 8'b10_000010, 8'b10_100100,
            8'b10_100101, 8'b10_100110, 8'b10_100111, 8'b10_101010};

    reset = 1'b1; flush = 1'b0; valid_in = 1'b0;
    ALUOp = '0; FuncField = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 64'(result), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_flags", 64'({out_valid, zero, illegal, busy}), 64'b0100);
    check("rst_operation", 64'(Operation), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(ready), 64'd1);

    // Directed plan items
    do_op(2'b10, 6'b100010, 32'd5, 32'd7, w);
    do_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, w);
    do_op(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, w);
    do_op(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'd2, w);
    do_op(2'b00, 6'b000000, 32'd1, 32'd1, w);
    check("issue_gap_after_mul", 64'(w), 64'd1);
    do_op(2'b10, 6'b011010, 32'd100, 32'd7, w);
    do_op(2'b10, 6'b011010, 32'd9, 32'd0, w);
    do_op(2'b10, 6'b111111, 32'd3, 32'd4, w);
    do_op(2'b01, 6'b000000, 32'h0000_00F0, 32'h0000_003C, w);
    do_op(2'b10, 6'b000000, 32'h8000_0001, 32'd31, w);
    do_op(2'b10, 6'b000010, 32'h8000_0001, 32'd63, w);

    // Flush mid-multiply: no pulse, outputs hold
    @(negedge clk);
    ALUOp = 2'b10; FuncField = 6'b011000; a = 32'd12345; b = 32'd678; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 64'({ready, busy, out_valid}), 64'b100);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("flush_no_pulse", 64'(pulses), 64'd0);
    check("flush_result_held", 64'(result), 64'(last_res));

    // flush beats a simultaneous valid_in
    ALUOp = 2'b00; a = 32'd1; b = 32'd2; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin valid_in = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("flush_blocks_accept", 64'({ready, out_valid}), 64'b10);

    // Reset mid-divide
    ALUOp = 2'b10; FuncField = 6'b011010; a = 32'd1000; b = 32'd3; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_result", 64'({result, hi}), 64'd0);
    check("midrst_flags", 64'({out_valid, zero, illegal, busy, Operation}), 64'b0100_0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(ready), 64'd1);
    do_op(2'b10, 6'b100000, 32'd40, 32'd2, w);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      sel = tbl[$urandom_range(13)];
      if ($urandom_range(7) == 0) sel[5:0] = 6'($urandom);
      x = $urandom;
      y = ($urandom_range(3) == 0) ? 32'($urandom_range(2)) : $urandom;
      do_op(sel[7:6], sel[5:0], x, y, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
